wb_arbiter_rr: RTL and testbench
================================

Name: wb_arbiter_rr

Overview:
Round-robin multi-master Wishbone B3 arbiter that sits directly upstream of the slave decoder (wb_decode). It merges MASTERS flattened master ports into one master bus for the decoder. Once a master is granted, it owns the bus for its whole cycle (m_cyc high), so bursts and read-modify-write are never split.

Parameters:
MASTERS, 2, number of master ports (1..16)
DATA_WIDTH, 32, data width in bits; multiple of 8
ADDR_WIDTH, 32, address width in bits
SEL_WIDTH, DATA_WIDTH/8, localparam, byte-select width
TIMEOUT, 256, stall-cycle limit; used only with WB_ARB_TIMEOUT_EN; must be >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
m_adr_i  in  ADDR_WIDTH*MASTERS  master addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_i  in  DATA_WIDTH*MASTERS  master write data
m_cyc_i  in  MASTERS  cycle valid per master
m_stb_i  in  MASTERS  strobe per master
m_sel_i  in  SEL_WIDTH*MASTERS  byte selects
m_we_i  in  MASTERS  write enable
m_cti_i  in  3*MASTERS  cycle type id
m_bte_i  in  2*MASTERS  burst type ext
m_dat_o  out  DATA_WIDTH*MASTERS  read data; s_dat_i broadcast to every master
m_ack_o  out  MASTERS  ack, granted master only
m_err_o  out  MASTERS  err, granted master only
m_rty_o  out  MASTERS  retry, granted master only
s_adr_o  out  ADDR_WIDTH  merged bus to decoder
s_dat_o  out  DATA_WIDTH  merged write data
s_cyc_o  out  1  merged cyc
s_stb_o  out  1  merged stb
s_sel_o  out  SEL_WIDTH  merged sel
s_we_o  out  1  merged we
s_cti_o  out  3  merged cti
s_bte_o  out  2  merged bte
s_dat_i  in  DATA_WIDTH  read data from decoder
s_ack_i  in  1  ack from decoder
s_err_i  in  1  err from decoder
s_rty_i  in  1  retry from decoder

Behaviour:
- State is a registered one-hot grant[MASTERS-1:0] plus a registered last-winner index last. IDLE means grant==0; BUSY means exactly one grant bit set.
- Reset (async, any time including mid-cycle): grant=0 and last=MASTERS-1, so master 0 has top priority first. All s_* outputs and m_ack_o/m_err_o/m_rty_o are 0 while in reset.
- Request vector is req=m_cyc_i.
- Transitions (registered, evaluated each clock edge):
  - IDLE with req!=0: grant the first set req bit, searching last+1, last+2, ... with wrap. Set last to the winner. The grant appears 1 cycle after cyc rises.
  - IDLE with req==0: stay IDLE.
  - BUSY with the granted master's cyc high: hold the grant. Requests from other masters are ignored (no preemption).
  - BUSY with the granted master's cyc low: re-arbitrate the same way, starting after the current owner. The next grant lands on the following edge, so there are 0 idle cycles between owners. If no other request is pending, go to IDLE.
  - MASTERS==1: the grant bit simply follows m_cyc_i, delayed 1 cycle.
- Forward path (combinational from grant):
  - The s_* outputs carry the granted master's signals.
  - s_cyc_o = m_cyc_i[g] & grant[g] and s_stb_o = m_stb_i[g] & grant[g]. As a result, s_cyc_o drops in the same cycle the owner drops cyc.
  - When IDLE, every s_* output is 0.
- Return path (combinational):
  - m_ack_o[i] = s_ack_i & grant[i], and likewise for err and rty.
  - m_dat_o replicates s_dat_i to every slot.
- Non-owners never see ack/err/rty, even if they hold stb high.
- Responses are passed through with no added latency.

Optional Feature:
WB_ARB_TIMEOUT_EN
- With the macro defined:
  - A counter of width clog2(TIMEOUT+1) clears on reset, on any s_ack_i/s_err_i/s_rty_i, when s_stb_o is low, and on any grant change.
  - Otherwise it increments every cycle that s_cyc_o & s_stb_o is high.
  - When count==TIMEOUT: m_err_o[owner] pulses high for 1 cycle, s_cyc_o and s_stb_o are forced to 0 in that cycle, and at the next edge the grant is released and re-arbitration runs excluding the owner for that cycle. The counter saturates; it never wraps.
- Without the macro: no counter logic; a stalled slave hangs the owner indefinitely.

Test Plan:
- Reset, then m_cyc_i=2'b01 → s_cyc_o=1 at cycle 1, grant=01; s_ack_i=1 → m_ack_o=2'b01, m_dat_o[63:32]==m_dat_o[31:0]==s_dat_i.
- m_cyc_i=2'b11 held from reset → master 0 wins. Master 0 drops cyc after 3 acks → master 1 granted on the next edge with 0 gap cycles. Master 1 drops cyc while master 0 re-requests → master 0 wins.
- 4-beat burst on master 1 (cti=3'b010 then 3'b111) while master 0 requests → grant stays on master 1 for all 4 acks; master 0 sees no ack.
- rst_i asserted mid-transfer while owner=master 1 → s_cyc_o=0 and grant=0 immediately (async); after release with both requesting, master 0 wins.
- WB_ARB_TIMEOUT_EN with TIMEOUT=4: master 0 stb high and no slave response → m_err_o[0]=1 on the 5th stall cycle with s_cyc_o=0 that cycle; master 1, if requesting, granted on the next edge.

Source files
------------

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: round-robin Wishbone B3 arbiter merging MASTERS ports onto one bus; optional stall timeout via WB_ARB_TIMEOUT_EN
module wb_arbiter_rr #(
   parameter int MASTERS    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 256,
   localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [ADDR_WIDTH*MASTERS-1:0]  m_adr_i,
   input  logic [DATA_WIDTH*MASTERS-1:0]  m_dat_i,
   input  logic [MASTERS-1:0]             m_cyc_i,
   input  logic [MASTERS-1:0]             m_stb_i,
   input  logic [SEL_WIDTH*MASTERS-1:0]   m_sel_i,
   input  logic [MASTERS-1:0]             m_we_i,
   input  logic [3*MASTERS-1:0]           m_cti_i,
   input  logic [2*MASTERS-1:0]           m_bte_i,
   output logic [DATA_WIDTH*MASTERS-1:0]  m_dat_o,
   output logic [MASTERS-1:0]             m_ack_o,
   output logic [MASTERS-1:0]             m_err_o,
   output logic [MASTERS-1:0]             m_rty_o,
   output logic [ADDR_WIDTH-1:0]          s_adr_o,
   output logic [DATA_WIDTH-1:0]          s_dat_o,
   output logic                           s_cyc_o,
   output logic                           s_stb_o,
   output logic [SEL_WIDTH-1:0]           s_sel_o,
   output logic                           s_we_o,
   output logic [2:0]                     s_cti_o,
   output logic [1:0]                     s_bte_o,
   input  logic [DATA_WIDTH-1:0]          s_dat_i,
   input  logic                           s_ack_i,
   input  logic                           s_err_i,
   input  logic                           s_rty_i
);
   localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   logic [MASTERS-1:0] r_grant, w_grant_nxt, w_req;
   logic [IW-1:0]      r_last, w_last_nxt, w_own, w_idx;
   logic               w_busy, w_hold, w_to, w_found;
   assign w_busy = |r_grant;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;
   logic          w_stb_raw, w_cyc_raw;
   assign w_stb_raw = w_busy & m_stb_i[w_own];
   assign w_cyc_raw = w_busy & m_cyc_i[w_own];
   assign w_to      = r_cnt == CW'(TIMEOUT);
   // stall counter: restarts on any response, idle strobe or ownership change, saturates at the limit
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_cnt <= '0;
      else if (s_ack_i | s_err_i | s_rty_i | ~w_stb_raw | (w_grant_nxt != r_grant))
         r_cnt <= '0;
      else if (w_cyc_raw & ~w_to)
         r_cnt <= r_cnt + 1'b1;
   end
`else
   assign w_to = 1'b0;
`endif
   // a timed-out owner is kept out of the arbitration round that releases it
   assign w_req  = m_cyc_i & ~(r_grant & {MASTERS{w_to}});
   assign w_hold = w_busy & m_cyc_i[w_own] & ~w_to;
   // binary index of the current owner (0 when idle; gated by w_busy downstream)
   always_comb begin
      w_own = '0;
      for (int i = 0; i < MASTERS; i++)
         if (r_grant[i]) w_own = IW'(i);
   end
   // round-robin search starting just after the last winner, only when the bus is free to change hands
   always_comb begin
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_found     = 1'b0;
      w_idx       = '0;
      if (!w_hold) begin
         w_grant_nxt = '0;
         for (int k = 1; k <= MASTERS; k++) begin
            w_idx = IW'((int'(r_last) + k) % MASTERS);
            if (!w_found && w_req[w_idx]) begin
               w_found            = 1'b1;
               w_grant_nxt[w_idx] = 1'b1;
               w_last_nxt         = w_idx;
            end
         end
      end
   end
   // grant and last-winner registers; reset favours master 0 first
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_grant <= '0;
         r_last  <= IW'(MASTERS - 1);
      end else begin
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
      end
   end
   assign s_adr_o = w_busy ? m_adr_i[w_own*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign s_dat_o = w_busy ? m_dat_i[w_own*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign s_sel_o = w_busy ? m_sel_i[w_own*SEL_WIDTH +: SEL_WIDTH] : '0;
   assign s_cti_o = w_busy ? m_cti_i[w_own*3 +: 3] : '0;
   assign s_bte_o = w_busy ? m_bte_i[w_own*2 +: 2] : '0;
   assign s_we_o  = w_busy & m_we_i[w_own];
   assign s_cyc_o = w_busy & m_cyc_i[w_own] & ~w_to;
   assign s_stb_o = w_busy & m_stb_i[w_own] & ~w_to;
   assign m_dat_o = {MASTERS{s_dat_i}};
   assign m_ack_o = r_grant & {MASTERS{s_ack_i}};
   assign m_err_o = r_grant & {MASTERS{s_err_i | w_to}};
   assign m_rty_o = r_grant & {MASTERS{s_rty_i}};
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr: directed bench for wb_arbiter_rr with an owner-index model checked every cycle
module tb_wb_arbiter_rr;
   localparam int M = 2, DW = 32, AW = 32, TMO = 4;
   localparam logic [AW-1:0] ADR0 = 32'h1000_0004, ADR1 = 32'h2000_0008;
   logic clk, rst;
   logic [AW*M-1:0] m_adr_i;
   logic [DW*M-1:0] m_dat_i, m_dat_o;
   logic [M-1:0] m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, m_rty_o;
   logic [4*M-1:0] m_sel_i;
   logic [3*M-1:0] m_cti_i;
   logic [2*M-1:0] m_bte_i;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o, s_dat_i;
   logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
   logic [3:0] s_sel_o;
   logic [2:0] s_cti_o;
   logic [1:0] s_bte_o;
   int errors = 0, checks = 0;
   int mo_own = -1, mo_last = M - 1, mo_cnt = 0;

   wb_arbiter_rr #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit tmo(input int own, input int cnt);
`ifdef WB_ARB_TIMEOUT_EN
      return own >= 0 && cnt == TMO;
`else
      return 0;
`endif
   endfunction

   // next owner: keep a live owner, otherwise the first requester after the last winner (timed-out owner excluded)
   function automatic int nxt_owner(input int own, input int last, input int cnt, input logic [M-1:0] cyc);
      int w;
      bit to;
      to = tmo(own, cnt);
      if (own >= 0 && cyc[own] && !to) return own;
      w = -1;
      for (int k = 1; k <= M; k++)
         if (w < 0 && cyc[(last + k) % M] && !(to && (last + k) % M == own)) w = (last + k) % M;
      return w;
   endfunction

   function automatic int nxt_cnt(input int own, input int nxt, input int cnt);
      bit stb, cyc;
      stb = own >= 0 && m_stb_i[own];
      cyc = own >= 0 && m_cyc_i[own];
      if (s_ack_i || s_err_i || s_rty_i || !stb || nxt != own) return 0;
      return (cyc && cnt < TMO) ? cnt + 1 : cnt;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mo_own  <= -1;
         mo_last <= M - 1;
         mo_cnt  <= 0;
      end else begin
         mo_own  <= nxt_owner(mo_own, mo_last, mo_cnt, m_cyc_i);
         mo_last <= (nxt_owner(mo_own, mo_last, mo_cnt, m_cyc_i) >= 0) ? nxt_owner(mo_own, mo_last, mo_cnt, m_cyc_i) : mo_last;
         mo_cnt  <= nxt_cnt(mo_own, nxt_owner(mo_own, mo_last, mo_cnt, m_cyc_i), mo_cnt);
      end
   end

   always @(negedge clk) begin
      logic [75:0] e_s;
      logic [M-1:0] e_ack, e_err, e_rty;
      bit to;
      to = tmo(mo_own, mo_cnt);
      e_s = '0;
      e_ack = '0;
      e_err = '0;
      e_rty = '0;
      if (mo_own >= 0) begin
         e_s = {m_adr_i[mo_own*AW +: AW], m_dat_i[mo_own*DW +: DW], m_cyc_i[mo_own] & ~to,
                m_stb_i[mo_own] & ~to, m_sel_i[mo_own*4 +: 4], m_we_i[mo_own],
                m_cti_i[mo_own*3 +: 3], m_bte_i[mo_own*2 +: 2]};
         e_ack[mo_own] = s_ack_i;
         e_err[mo_own] = s_err_i | to;
         e_rty[mo_own] = s_rty_i;
      end
      chk("s_bus", {s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_sel_o, s_we_o, s_cti_o, s_bte_o}, e_s);
      chk("m_rsp", {m_ack_o, m_err_o, m_rty_o, m_dat_o}, {e_ack, e_err, e_rty, {M{s_dat_i}}});
   end

   initial begin
      rst = 1;
      m_adr_i = {ADR1, ADR0};
      m_dat_i = {32'h2222_bbbb, 32'h1111_aaaa};
      m_sel_i = {4'hC, 4'h3};
      m_we_i  = 2'b10;
      m_cti_i = '0;
      m_bte_i = {2'b10, 2'b01};
      m_cyc_i = '0;
      m_stb_i = '0;
      s_dat_i = 32'h5a5a_0f0f;
      s_ack_i = 1;
      s_err_i = 0;
      s_rty_i = 0;
      #12;
      chk("rst_cyc", s_cyc_o, 0);
      chk("rst_ack", m_ack_o, 0);
      rst = 0;
      s_ack_i = 0;
      m_cyc_i = 2'b01;
      m_stb_i = 2'b01;
      #1 chk("lat0_cyc", s_cyc_o, 0);
      tick;
      chk("g0_cyc", s_cyc_o, 1);
      chk("g0_adr", s_adr_o, ADR0);
      s_ack_i = 1;
      s_dat_i = 32'hdead_beef;
      #1 chk("g0_ack", m_ack_o, 2'b01);
      chk("g0_bcast", m_dat_o, {2{32'hdead_beef}});
      tick;
      m_cyc_i = 0;
      m_stb_i = 0;
      s_ack_i = 0;
      #1 chk("drop_cyc", s_cyc_o, 0);
      tick;
      rst = 1;
      #1 rst = 0;
      m_cyc_i = 2'b11;
      m_stb_i = 2'b11;
      tick;
      chk("both_m0", s_adr_o, ADR0);
      s_ack_i = 1;
      for (int b = 0; b < 3; b++) begin
         #1 chk("m0_ack", m_ack_o, 2'b01);
         tick;
      end
      m_cyc_i = 2'b10;
      m_stb_i = 2'b10;
      s_ack_i = 0;
      #1 chk("m0_drop", s_cyc_o, 0);
      tick;
      chk("m1_nogap_adr", s_adr_o, ADR1);
      chk("m1_nogap_cyc", s_cyc_o, 1);
      m_cyc_i = 2'b01;
      m_stb_i = 2'b01;
      tick;
      chk("m0_back", s_adr_o, ADR0);
      m_cyc_i = 2'b10;
      m_stb_i = 2'b10;
      tick;
      chk("burst_own", s_adr_o, ADR1);
      m_cyc_i = 2'b11;
      m_stb_i = 2'b11;
      m_cti_i = {3'b010, 3'b000};
      s_ack_i = 1;
      for (int b = 0; b < 4; b++) begin
         if (b == 3) m_cti_i = {3'b111, 3'b000};
         #1 chk("burst_ack", m_ack_o, 2'b10);
         chk("burst_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
         tick;
      end
      m_cyc_i = 2'b01;
      m_stb_i = 2'b01;
      m_cti_i = '0;
      s_ack_i = 0;
      tick;
      chk("after_burst", s_adr_o, ADR0);
      m_cyc_i = 2'b10;
      m_stb_i = 2'b10;
      tick;
      chk("pre_rst_own", s_adr_o, ADR1);
      m_cyc_i = 2'b11;
      m_stb_i = 2'b11;
      s_ack_i = 1;
      #1 rst = 1;
      #1 chk("async_cyc", s_cyc_o, 0);
      chk("async_ack", m_ack_o, 0);
      #1 rst = 0;
      s_ack_i = 0;
      tick;
      chk("post_rst_m0", s_adr_o, ADR0);
      rst = 1;
      #1 rst = 0;
      tick;
      repeat (4) tick;
`ifdef WB_ARB_TIMEOUT_EN
      chk("tmo_err", m_err_o, 2'b01);
      chk("tmo_cyc", s_cyc_o, 0);
      tick;
      chk("tmo_next", s_adr_o, ADR1);
      chk("tmo_next_cyc", s_cyc_o, 1);
`else
      chk("hang_err", m_err_o, 2'b00);
      chk("hang_cyc", s_cyc_o, 1);
      tick;
      chk("hang_own", s_adr_o, ADR0);
`endif
      m_cyc_i = 0;
      m_stb_i = 0;
      repeat (3) tick;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
